pipeline_controller: RTL and testbench
======================================

PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

Interface
REQ-001 SHALL have parameter INIT_CYCLES, default 2, the number of post-reset cycles spent in INIT.
REQ-002 SHALL have parameter WAIT_LIMIT, default 8, the maximum number of BR_WAIT cycles before timeout.
REQ-003 SHALL have parameter COUNT_WIDTH, default 32, the width of stall_cycles.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_h, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port opcode_from_icache, input, 7 bits: opcode of the instruction currently in IF/ID.
REQ-007 SHALL have ports rs1_from_icache and rs2_from_icache, input, 5 bits each: source register fields of the IF/ID instruction.
REQ-008 SHALL have port read_mem_from_decoder, input, 1 bit: the ID/EX instruction is a load.
REQ-009 SHALL have port rd_from_decoder, input, 5 bits: destination register of the ID/EX instruction.
REQ-010 SHALL have port branch_resolved_from_execute, input, 1 bit: execute resolves a control instruction this cycle.
REQ-011 SHALL have port branch_taken_from_execute, input, 1 bit: the resolved control instruction redirects the PC; valid only with resolved.
REQ-012 SHALL have port mem_stall_from_memory, input, 1 bit: the memory stage requests a full-pipeline hold.
REQ-013 SHALL have port stall_fetch, output, 1 bit: PC and IF/ID hold their values.
REQ-014 SHALL have port bubble_decoder, output, 1 bit: the decoder loads all-zero ID/EX contents.
REQ-015 SHALL have port flush_fetch, output, 1 bit: IF/ID loads all-zero contents.
REQ-016 SHALL have port hold_pipeline, output, 1 bit: every stage register holds its value.
REQ-017 SHALL have port state_out, output, 2 bits: current state encoding, INIT=0, RUN=1, BR_WAIT=2.
REQ-018 SHALL have port timeout_error, output, 1 bit: sticky BR_WAIT timeout flag.
REQ-019 SHALL have port stall_cycles, output, COUNT_WIDTH bits: saturating count of bubble cycles.

Function
REQ-020 SHALL drive stall_fetch, bubble_decoder, flush_fetch and hold_pipeline combinationally from the current state and inputs; state, counters and timeout_error SHALL be registered.
REQ-021 SHALL, while mem_stall_from_memory=1 in any state, assert hold_pipeline=1, force stall_fetch=bubble_decoder=flush_fetch=0, and freeze state, wait counter, init counter and stall_cycles.
REQ-022 SHALL, in INIT, drive stall_fetch=0 and bubble_decoder=1, and move to RUN once INIT_CYCLES cycles have elapsed.
REQ-023 SHALL define load_use = read_mem_from_decoder AND rd_from_decoder!=0 AND (rd_from_decoder==rs1_from_icache OR rd_from_decoder==rs2_from_icache).
REQ-024 SHALL define is_ctrl = opcode_from_icache equal to 1100011, 1101111 or 1100111.
REQ-025 SHALL, in RUN when load_use=1, drive stall_fetch=1 and bubble_decoder=1 for that cycle and remain in RUN; load_use SHALL take priority over is_ctrl.
REQ-026 SHALL, in RUN when is_ctrl=1 and load_use=0, drive bubble_decoder=0 (instruction enters ID/EX) and stall_fetch=1, and move to BR_WAIT with the wait counter cleared.
REQ-027 SHALL, in RUN otherwise, drive all four control outputs to 0.
REQ-028 SHALL, in BR_WAIT with resolved=0, drive stall_fetch=1 and bubble_decoder=1 and increment the wait counter.
REQ-029 SHALL, in BR_WAIT with resolved=1, drive bubble_decoder=1, flush_fetch=taken and stall_fetch=NOT taken, then move to RUN.
REQ-030 SHALL, in BR_WAIT when the wait counter equals WAIT_LIMIT-1 and resolved=0, set timeout_error and move to RUN.
REQ-031 SHALL ignore branch_resolved_from_execute outside BR_WAIT.
REQ-032 SHALL increment stall_cycles on every non-hold cycle with bubble_decoder=1 in RUN or BR_WAIT, saturating at all-ones without wrapping.

Reset
REQ-033 SHALL, when rst_h=1 at a clock edge, enter INIT, clear the init counter, wait counter, stall_cycles and timeout_error, regardless of mem_stall or the current state.
REQ-034 SHALL, during and immediately after reset, present INIT outputs: stall_fetch=0, bubble_decoder=1, flush_fetch=0, hold_pipeline=0 (hold_pipeline=1 only if mem_stall=1).

Verification
REQ-035 SHALL be covered by this scenario: release reset with INIT_CYCLES=2 -> state_out=0 for 2 cycles with bubble=1, then state_out=1 and stall_cycles=0.
REQ-036 SHALL be covered by this scenario: ID/EX load with rd=5 and IF/ID rs2=5 -> exactly one cycle with stall_fetch=1 and bubble=1, then outputs return to 0; the same case with rd=0 -> no stall.
REQ-037 SHALL be covered by this scenario: BEQ in IF/ID, resolved+taken 3 cycles later -> BR_WAIT for 3 cycles, resolve cycle flush_fetch=1 and stall_fetch=0, stall_cycles increases by 3.
REQ-038 SHALL be covered by this scenario: JAL with resolved and taken=0 on the second BR_WAIT cycle -> resolve cycle stall_fetch=1 and flush_fetch=0, next cycle RUN.
REQ-039 SHALL be covered by this scenario: no resolve for 8 BR_WAIT cycles -> timeout_error=1 and RUN, and it stays 1 until reset.
REQ-040 SHALL be covered by this scenario: mem_stall=1 for 4 cycles mid-BR_WAIT -> hold_pipeline=1, state and counters frozen, BR_WAIT resumes afterwards; rst_h=1 during the hold -> INIT next cycle.

Source files
------------

// File: rtl/pipeline_controller.sv
// Pipeline hazard controller: load-use stalls, branch wait/resolve
// sequencing, full-pipeline memory hold and bubble-cycle accounting.
module pipeline_controller #(
    parameter int INIT_CYCLES = 2,
    parameter int WAIT_LIMIT  = 8,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_h,
    input  logic [6:0]             opcode_from_icache,
    input  logic [4:0]             rs1_from_icache,
    input  logic [4:0]             rs2_from_icache,
    input  logic                   read_mem_from_decoder,
    input  logic [4:0]             rd_from_decoder,
    input  logic                   branch_resolved_from_execute,
    input  logic                   branch_taken_from_execute,
    input  logic                   mem_stall_from_memory,
    output logic                   stall_fetch,
    output logic                   bubble_decoder,
    output logic                   flush_fetch,
    output logic                   hold_pipeline,
    output logic [1:0]             state_out,
    output logic                   timeout_error,
    output logic [COUNT_WIDTH-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        INIT    = 2'd0,
        RUN     = 2'd1,
        BR_WAIT = 2'd2
    } state_t;

    localparam int IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam int WW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
    localparam logic [IW-1:0] INIT_LAST =
        IW'((INIT_CYCLES > 0) ? INIT_CYCLES - 1 : 0);
    localparam logic [WW-1:0] WAIT_LAST =
        WW'((WAIT_LIMIT > 0) ? WAIT_LIMIT - 1 : 0);

    state_t          state;
    state_t          next_state;
    state_t          cur;
    logic [IW-1:0]   init_cnt;
    logic [WW-1:0]   wait_cnt;
    logic            init_inc;
    logic            wait_inc;
    logic            wait_clr;
    logic            timeout_set;
    logic            load_use;
    logic            is_ctrl;

    assign load_use = read_mem_from_decoder
                   && (rd_from_decoder != 5'd0)
                   && ((rd_from_decoder == rs1_from_icache)
                    || (rd_from_decoder == rs2_from_icache));

    assign is_ctrl = (opcode_from_icache == 7'b1100011)
                  || (opcode_from_icache == 7'b1101111)
                  || (opcode_from_icache == 7'b1100111);

    // Reset forces INIT outputs even before the first reset edge lands.
    assign cur       = rst_h ? INIT : state;
    assign state_out = state;

    always_comb begin
        next_state     = state;
        stall_fetch    = 1'b0;
        bubble_decoder = 1'b0;
        flush_fetch    = 1'b0;
        hold_pipeline  = 1'b0;
        init_inc       = 1'b0;
        wait_inc       = 1'b0;
        wait_clr       = 1'b0;
        timeout_set    = 1'b0;
        if (mem_stall_from_memory) begin
            hold_pipeline = 1'b1;
        end else begin
            case (cur)
                INIT: begin
                    bubble_decoder = 1'b1;
                    if (init_cnt >= INIT_LAST) next_state = RUN;
                    else init_inc = 1'b1;
                end
                RUN: begin
                    if (load_use) begin
                        stall_fetch    = 1'b1;
                        bubble_decoder = 1'b1;
                    end else if (is_ctrl) begin
                        stall_fetch = 1'b1;
                        wait_clr    = 1'b1;
                        next_state  = BR_WAIT;
                    end
                end
                BR_WAIT: begin
                    bubble_decoder = 1'b1;
                    if (branch_resolved_from_execute) begin
                        flush_fetch = branch_taken_from_execute;
                        stall_fetch = !branch_taken_from_execute;
                        next_state  = RUN;
                    end else begin
                        stall_fetch = 1'b1;
                        wait_inc    = 1'b1;
                        if (wait_cnt == WAIT_LAST) begin
                            timeout_set = 1'b1;
                            next_state  = RUN;
                        end
                    end
                end
                default: next_state = INIT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_h) begin
            state         <= INIT;
            init_cnt      <= '0;
            wait_cnt      <= '0;
            stall_cycles  <= '0;
            timeout_error <= 1'b0;
        end else if (!mem_stall_from_memory) begin
            state <= next_state;
            if (init_inc) init_cnt <= init_cnt + IW'(1);
            if (wait_clr) wait_cnt <= '0;
            else if (wait_inc) wait_cnt <= wait_cnt + WW'(1);
            if (timeout_set) timeout_error <= 1'b1;
            if (bubble_decoder && (state != INIT) && (stall_cycles != '1))
                stall_cycles <= stall_cycles + COUNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_controller.sv
// Scoreboard bench for pipeline_controller: stimulus pushes expected
// per-cycle outputs, a negedge monitor pops and compares them.
module tb_pipeline_controller;

    localparam int CW = 4;

    logic          clk;
    logic          rst_h;
    logic [6:0]    opcode_from_icache;
    logic [4:0]    rs1_from_icache;
    logic [4:0]    rs2_from_icache;
    logic          read_mem_from_decoder;
    logic [4:0]    rd_from_decoder;
    logic          branch_resolved_from_execute;
    logic          branch_taken_from_execute;
    logic          mem_stall_from_memory;
    logic          stall_fetch;
    logic          bubble_decoder;
    logic          flush_fetch;
    logic          hold_pipeline;
    logic [1:0]    state_out;
    logic          timeout_error;
    logic [CW-1:0] stall_cycles;

    typedef struct {
        string      nm;
        logic [1:0] st;
        logic [3:0] ctl;
        logic       to;
        int         sc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [6:0] NOP  = 7'b0010011;
    localparam logic [6:0] BEQ  = 7'b1100011;
    localparam logic [6:0] JAL  = 7'b1101111;
    localparam logic [6:0] JALR = 7'b1100111;

    // ctl bit order: {stall_fetch, bubble_decoder, flush_fetch, hold_pipeline}
    localparam logic [3:0] C_NONE = 4'b0000;
    localparam logic [3:0] C_BUB  = 4'b0100;
    localparam logic [3:0] C_STB  = 4'b1100;
    localparam logic [3:0] C_STL  = 4'b1000;
    localparam logic [3:0] C_FLB  = 4'b0110;
    localparam logic [3:0] C_HOLD = 4'b0001;

    pipeline_controller #(
        .INIT_CYCLES(2),
        .WAIT_LIMIT (8),
        .COUNT_WIDTH(CW)
    ) dut (
        .clk                         (clk),
        .rst_h                       (rst_h),
        .opcode_from_icache          (opcode_from_icache),
        .rs1_from_icache             (rs1_from_icache),
        .rs2_from_icache             (rs2_from_icache),
        .read_mem_from_decoder       (read_mem_from_decoder),
        .rd_from_decoder             (rd_from_decoder),
        .branch_resolved_from_execute(branch_resolved_from_execute),
        .branch_taken_from_execute   (branch_taken_from_execute),
        .mem_stall_from_memory       (mem_stall_from_memory),
        .stall_fetch                 (stall_fetch),
        .bubble_decoder              (bubble_decoder),
        .flush_fetch                 (flush_fetch),
        .hold_pipeline               (hold_pipeline),
        .state_out                   (state_out),
        .timeout_error               (timeout_error),
        .stall_cycles                (stall_cycles)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic idle();
        rst_h                        = 1'b0;
        mem_stall_from_memory        = 1'b0;
        read_mem_from_decoder        = 1'b0;
        rd_from_decoder              = 5'd0;
        rs1_from_icache              = 5'd0;
        rs2_from_icache              = 5'd0;
        opcode_from_icache           = NOP;
        branch_resolved_from_execute = 1'b0;
        branch_taken_from_execute    = 1'b0;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic expect_out(input string nm, input logic [1:0] st,
                              input logic [3:0] ctl, input logic to,
                              input int sc);
        exp_t e;
        e.nm  = nm;
        e.st  = st;
        e.ctl = ctl;
        e.to  = to;
        e.sc  = sc;
        q.push_back(e);
    endtask

    task automatic load(input logic [4:0] rd, input logic [4:0] r1,
                        input logic [4:0] r2);
        read_mem_from_decoder = 1'b1;
        rd_from_decoder       = rd;
        rs1_from_icache       = r1;
        rs2_from_icache       = r2;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [3:0] act;
            e   = q.pop_front();
            act = {stall_fetch, bubble_decoder, flush_fetch, hold_pipeline};
            checks = checks + 1;
            if (state_out !== e.st || act !== e.ctl ||
                timeout_error !== e.to || int'(stall_cycles) != e.sc) begin
                errors = errors + 1;
                $display("FAIL %s: got state %0d ctl %b to %b sc %0d, want state %0d ctl %b to %b sc %0d",
                         e.nm, state_out, act, timeout_error, stall_cycles,
                         e.st, e.ctl, e.to, e.sc);
            end
        end
    end

    initial begin
        idle();
        rst_h = 1'b1;
        nxt(); rst_h = 1'b1;
        expect_out("reset", 0, C_BUB, 0, 0);
        nxt(); rst_h = 1'b1; mem_stall_from_memory = 1'b1;
        expect_out("reset_hold", 0, C_HOLD, 0, 0);

        nxt(); expect_out("init1", 0, C_BUB, 0, 0);
        nxt(); expect_out("init2", 0, C_BUB, 0, 0);
        nxt(); expect_out("run_idle", 1, C_NONE, 0, 0);

        nxt(); load(5, 3, 5);
        expect_out("load_use_rs2", 1, C_STB, 0, 0);
        nxt(); expect_out("after_load_use", 1, C_NONE, 0, 1);
        nxt(); load(0, 0, 0);
        expect_out("load_rd0", 1, C_NONE, 0, 1);
        nxt(); load(7, 7, 2);
        expect_out("load_use_rs1", 1, C_STB, 0, 1);
        nxt(); load(9, 9, 1); opcode_from_icache = BEQ;
        expect_out("load_use_prio", 1, C_STB, 0, 2);
        nxt(); rd_from_decoder = 5'd4; rs1_from_icache = 5'd4;
        expect_out("no_load_match", 1, C_NONE, 0, 3);

        nxt(); opcode_from_icache = BEQ;
        expect_out("beq_issue", 1, C_STL, 0, 3);
        nxt(); expect_out("beq_wait1", 2, C_STB, 0, 3);
        nxt(); expect_out("beq_wait2", 2, C_STB, 0, 4);
        nxt(); branch_resolved_from_execute = 1'b1;
        branch_taken_from_execute = 1'b1;
        expect_out("beq_taken", 2, C_FLB, 0, 5);
        nxt(); expect_out("beq_run", 1, C_NONE, 0, 6);

        nxt(); opcode_from_icache = JAL;
        expect_out("jal_issue", 1, C_STL, 0, 6);
        nxt(); expect_out("jal_wait1", 2, C_STB, 0, 6);
        nxt(); branch_resolved_from_execute = 1'b1;
        expect_out("jal_not_taken", 2, C_STB, 0, 7);
        nxt(); expect_out("jal_run", 1, C_NONE, 0, 8);
        nxt(); branch_resolved_from_execute = 1'b1;
        branch_taken_from_execute = 1'b1;
        expect_out("resolve_in_run", 1, C_NONE, 0, 8);

        nxt(); opcode_from_icache = JALR;
        expect_out("jalr_issue", 1, C_STL, 0, 8);
        nxt(); expect_out("jalr_wait1", 2, C_STB, 0, 8);
        for (int k = 0; k < 4; k++) begin
            nxt(); mem_stall_from_memory = 1'b1;
            expect_out("mem_hold", 2, C_HOLD, 0, 9);
        end
        nxt(); expect_out("jalr_wait2", 2, C_STB, 0, 9);
        nxt(); branch_resolved_from_execute = 1'b1;
        branch_taken_from_execute = 1'b1;
        expect_out("jalr_taken", 2, C_FLB, 0, 10);

        nxt(); opcode_from_icache = BEQ;
        expect_out("beq2_issue", 1, C_STL, 0, 11);
        nxt(); mem_stall_from_memory = 1'b1;
        expect_out("hold_bw", 2, C_HOLD, 0, 11);
        nxt(); mem_stall_from_memory = 1'b1; rst_h = 1'b1;
        expect_out("rst_in_hold", 2, C_HOLD, 0, 11);
        nxt(); expect_out("init_after_rst", 0, C_BUB, 0, 0);
        nxt(); expect_out("init2_after_rst", 0, C_BUB, 0, 0);
        nxt(); expect_out("run_after_rst", 1, C_NONE, 0, 0);

        nxt(); opcode_from_icache = BEQ;
        expect_out("to_issue", 1, C_STL, 0, 0);
        for (int k = 1; k <= 8; k++) begin
            nxt(); expect_out("to_wait", 2, C_STB, 0, k - 1);
        end
        nxt(); expect_out("timeout_run", 1, C_NONE, 1, 8);

        nxt(); opcode_from_icache = BEQ;
        expect_out("sat_issue", 1, C_STL, 1, 8);
        for (int k = 1; k <= 8; k++) begin
            nxt(); expect_out("sat_wait", 2, C_STB, 1, 7 + k);
        end
        nxt(); expect_out("sat_run", 1, C_NONE, 1, 15);
        nxt(); load(3, 3, 0);
        expect_out("sat_load_use", 1, C_STB, 1, 15);
        nxt(); expect_out("sat_hold", 1, C_NONE, 1, 15);

        nxt(); rst_h = 1'b1;
        expect_out("final_rst", 1, C_BUB, 1, 15);
        nxt(); expect_out("post_rst", 0, C_BUB, 0, 0);

        for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
        #1;
        if (q.size() > 0) begin
            errors = errors + 1;
            $display("FAIL drain: %0d entries left, want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
